// File: rtl/ysyx_25040109_axi_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU to MEM AXI4-Lite arbiter.
package ysyx_25040109_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ysyx_25040109_axi_arbiter_if.sv
// AXI4-Lite bundles: a read-only bundle for instruction fetch and a full read/write bundle.
import ysyx_25040109_arb_pkg::*;

interface ysyx_25040109_axi_arbiter_rd_if #(
    parameter int ADDR_W = ysyx_25040109_arb_pkg::ADDR_W,
    parameter int DATA_W = ysyx_25040109_arb_pkg::DATA_W
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );
    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

interface ysyx_25040109_axi_arbiter_if #(
    parameter int ADDR_W = ysyx_25040109_arb_pkg::ADDR_W,
    parameter int DATA_W = ysyx_25040109_arb_pkg::DATA_W
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25040109_axi_arbiter_mux.sv
// Channel routing between the granted master and MEM; purely combinational from the grant state.
import ysyx_25040109_arb_pkg::*;

module ysyx_25040109_arb_mux (
    input arb_state_t                     state,
    ysyx_25040109_axi_arbiter_rd_if.slave ifu,
    ysyx_25040109_axi_arbiter_if.slave    lsu,
    ysyx_25040109_axi_arbiter_if.master   mem
);

    always_comb begin
        mem.araddr  = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;

        ifu.arready = 1'b0;
        ifu.rdata   = '0;
        ifu.rresp   = RESP_OKAY;
        ifu.rvalid  = 1'b0;

        lsu.arready = 1'b0;
        lsu.rdata   = '0;
        lsu.rresp   = RESP_OKAY;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = RESP_OKAY;
        lsu.bvalid  = 1'b0;

        case (state)
            IFU_RD: begin
                mem.araddr  = ifu.araddr;
                mem.arvalid = ifu.arvalid;
                mem.rready  = ifu.rready;
                ifu.arready = mem.arready;
                ifu.rdata   = mem.rdata;
                ifu.rresp   = mem.rresp;
                ifu.rvalid  = mem.rvalid;
            end
            LSU_RD: begin
                mem.araddr  = lsu.araddr;
                mem.arvalid = lsu.arvalid;
                mem.rready  = lsu.rready;
                lsu.arready = mem.arready;
                lsu.rdata   = mem.rdata;
                lsu.rresp   = mem.rresp;
                lsu.rvalid  = mem.rvalid;
            end
            // AW, W and B travel together so the two write beats may land in any order
            LSU_WR: begin
                mem.awaddr  = lsu.awaddr;
                mem.awvalid = lsu.awvalid;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wvalid  = lsu.wvalid;
                mem.bready  = lsu.bready;
                lsu.awready = mem.awready;
                lsu.wready  = mem.wready;
                lsu.bresp   = mem.bresp;
                lsu.bvalid  = mem.bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_axi_arbiter.sv
// Two-master AXI4-Lite arbiter (IFU, LSU) onto the single MEM port, one transaction at a time.
// Define ARB_RR_EN for round-robin between colliding reads; otherwise LSU reads beat IFU.
//
// state  | meaning
// IDLE   | nothing routed; pick the next master from pending valids
// IFU_RD | IFU read channels routed to MEM until R handshake
// LSU_RD | LSU read channels routed to MEM until R handshake
// LSU_WR | LSU AW/W/B routed to MEM until B handshake
import ysyx_25040109_arb_pkg::*;

module ysyx_25040109_axi_arbiter (
    input logic                           clk,
    input logic                           rst,
    ysyx_25040109_axi_arbiter_rd_if.slave ifu,
    ysyx_25040109_axi_arbiter_if.slave    lsu,
    ysyx_25040109_axi_arbiter_if.master   mem
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       rd_pick_lsu;

`ifdef ARB_RR_EN
    logic last_rd;  // 0: IFU served last, 1: LSU served last

    always_comb rd_pick_lsu = lsu.arvalid && (!ifu.arvalid || !last_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd <= 1'b0;
        end else if (state == IDLE && (state_nxt == IFU_RD || state_nxt == LSU_RD)) begin
            last_rd <= (state_nxt == LSU_RD);
        end
    end
`else
    always_comb rd_pick_lsu = lsu.arvalid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Exits always land in IDLE, which guarantees a bubble before the next grant
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lsu.awvalid) begin
                    state_nxt = LSU_WR;
                end else if (rd_pick_lsu) begin
                    state_nxt = LSU_RD;
                end else if (ifu.arvalid) begin
                    state_nxt = IFU_RD;
                end
            end
            IFU_RD: if (mem.rvalid && ifu.rready) state_nxt = IDLE;
            LSU_RD: if (mem.rvalid && lsu.rready) state_nxt = IDLE;
            LSU_WR: if (mem.bvalid && lsu.bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    ysyx_25040109_arb_mux u_mux (
        .state (state),
        .ifu   (ifu),
        .lsu   (lsu),
        .mem   (mem)
    );

`ifndef SYNTHESIS
    // A master dropping valid before its handshake breaks AXI; the grant is simply held
    logic [3:0] wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= {ifu.arvalid & ~ifu.arready, lsu.arvalid & ~lsu.arready,
                       lsu.awvalid & ~lsu.awready, lsu.wvalid & ~lsu.wready};
            if ((wait_q & ~{ifu.arvalid, lsu.arvalid, lsu.awvalid, lsu.wvalid}) != 4'b0) begin
                $fatal(1, "axi_arbiter: valid withdrawn before handshake (%b)", wait_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25040109_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI4-Lite arbiter with a single-outstanding MEM model.
`timescale 1ns/1ps
import ysyx_25040109_arb_pkg::*;

module tb_ysyx_25040109_axi_arbiter;

    localparam int RD_LAT = 2;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    ysyx_25040109_axi_arbiter_rd_if ifu ();
    ysyx_25040109_axi_arbiter_if    lsu ();
    ysyx_25040109_axi_arbiter_if    mem ();

    ysyx_25040109_axi_arbiter dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu),
        .lsu (lsu),
        .mem (mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- MEM model: one read and one write outstanding at most
    logic        rd_busy;
    int          rd_cnt;
    logic [31:0] rd_addr_q;
    int          ar_count;
    logic        aw_got, w_got;
    logic [31:0] wa_q, wd_q;
    logic [3:0]  ws_q;
    int          b_count;

    function automatic logic [33:0] mem_lookup(input logic [31:0] a);
        if (a < 32'h8000_0000) return {RESP_SLVERR, 32'h0};
        case (a)
            32'h8000_0000: return {RESP_OKAY, 32'h0000_0413};
            32'h8000_1000: return {RESP_OKAY, 32'h1234_5678};
            default:       return {RESP_OKAY, a ^ 32'hA5A5_A5A5};
        endcase
    endfunction

    assign mem.arready = !rd_busy;
    assign mem.awready = !aw_got && !mem.bvalid;
    assign mem.wready  = !w_got && !mem.bvalid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_busy <= 1'b0; rd_cnt <= 0; rd_addr_q <= '0;
            mem.rvalid <= 1'b0; mem.rdata <= '0; mem.rresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; wa_q <= '0; wd_q <= '0; ws_q <= '0;
            mem.bvalid <= 1'b0; mem.bresp <= '0;
        end else begin
            if (mem.arvalid && mem.arready) begin
                rd_busy <= 1'b1; rd_cnt <= RD_LAT; rd_addr_q <= mem.araddr;
                ar_count <= ar_count + 1;
            end else if (rd_busy && !mem.rvalid) begin
                if (rd_cnt == 1) begin
                    mem.rvalid <= 1'b1;
                    {mem.rresp, mem.rdata} <= mem_lookup(rd_addr_q);
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end
            if (mem.rvalid && mem.rready) begin
                mem.rvalid <= 1'b0; rd_busy <= 1'b0; mem.rdata <= '0; mem.rresp <= '0;
            end
            if (mem.awvalid && mem.awready) begin aw_got <= 1'b1; wa_q <= mem.awaddr; end
            if (mem.wvalid && mem.wready) begin w_got <= 1'b1; wd_q <= mem.wdata; ws_q <= mem.wstrb; end
            if (aw_got && w_got && !mem.bvalid) begin mem.bvalid <= 1'b1; mem.bresp <= RESP_OKAY; end
            if (mem.bvalid && mem.bready) begin
                mem.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_count <= b_count + 1;
            end
        end
    end

    // ---------------- side monitors
    logic mon_lsu_quiet = 1'b0;
    logic mon_ifu_block = 1'b0;
    int   lsu_noise = 0;
    int   ifu_leak = 0;

    always @(negedge clk) begin
        if (mon_lsu_quiet && (lsu.arready || lsu.rvalid || lsu.awready || lsu.wready || lsu.bvalid ||
                              (|lsu.rdata) || (|lsu.rresp) || (|lsu.bresp)))
            lsu_noise <= lsu_noise + 1;
        if (mon_ifu_block && ifu.arready) ifu_leak <= ifu_leak + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read from IFU (use_lsu=0) or LSU; lat counts edges until rvalid is seen
    task automatic do_read(input bit use_lsu, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output int done_cyc);
        bit ar_f, r_f, got;
        got = 0; lat = 0; data = '0; resp = '0; done_cyc = -1;
        if (use_lsu) begin lsu.araddr = addr; lsu.arvalid = 1'b1; end
        else begin ifu.araddr = addr; ifu.arvalid = 1'b1; end
        for (int n = 0; n < 64 && !got; n++) begin
            ar_f = use_lsu ? (lsu.arvalid && lsu.arready) : (ifu.arvalid && ifu.arready);
            r_f  = use_lsu ? (lsu.rvalid && lsu.rready) : (ifu.rvalid && ifu.rready);
            if (r_f) begin
                data = use_lsu ? lsu.rdata : ifu.rdata;
                resp = use_lsu ? lsu.rresp : ifu.rresp;
                done_cyc = cyc;
                got = 1;
            end else begin
                lat++;
            end
            @(posedge clk); #1;
            if (ar_f) begin
                if (use_lsu) lsu.arvalid = 1'b0; else ifu.arvalid = 1'b0;
            end
        end
        check(use_lsu ? "lsu_rd_done" : "ifu_rd_done", 64'(got), 64'd1);
    endtask

    function automatic logic any_out();
        return ifu.arready || ifu.rvalid || (|ifu.rdata) || (|ifu.rresp) ||
               lsu.arready || lsu.rvalid || (|lsu.rdata) || (|lsu.rresp) ||
               lsu.awready || lsu.wready || lsu.bvalid || (|lsu.bresp) ||
               mem.arvalid || mem.rready || (|mem.araddr) || mem.awvalid || (|mem.awaddr) ||
               mem.wvalid || (|mem.wdata) || (|mem.wstrb) || mem.bready;
    endfunction

    logic [31:0] d0, d1;
    logic [1:0]  r0, r1;
    int          l0, l1, c0, c1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          aw_f, w_f, b_f, bdone;
        logic [1:0]  bresp_seen;
        int          b_base, ar_base, ar_n, r_n, idle_cnt, last_r, gap_bad, idle_bad, seen;
        logic [31:0] exp_addr;

        rst = 1'b1;
        ar_count = 0; b_count = 0;
        ifu.araddr = '0; ifu.arvalid = 1'b0; ifu.rready = 1'b0;
        lsu.araddr = '0; lsu.arvalid = 1'b0; lsu.rready = 1'b0;
        lsu.awaddr = '0; lsu.awvalid = 1'b0; lsu.wdata = '0; lsu.wstrb = '0;
        lsu.wvalid = 1'b0; lsu.bready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_outputs_zero", 64'(any_out()), 64'd0);
        rst = 1'b0;
        ifu.rready = 1'b1; lsu.rready = 1'b1; lsu.bready = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs_zero", 64'(any_out()), 64'd0);

        // 1: IFU alone
        mon_lsu_quiet = 1'b1;
        do_read(0, 32'h8000_0000, d0, r0, l0, c0);
        mon_lsu_quiet = 1'b0;
        check("t1_rdata", 64'(d0), 64'h0000_0413);
        check("t1_rresp", 64'(r0), 64'd0);
        check("t1_latency", 64'(l0), 64'(RD_LAT + 2));
        check("t1_lsu_quiet", 64'(lsu_noise), 64'd0);

        // 2: simultaneous reads, LSU first then IFU after the bubble
        fork
            do_read(1, 32'h8000_1000, d1, r1, l1, c1);
            do_read(0, 32'h8000_0000, d0, r0, l0, c0);
        join
        check("t2_lsu_rdata", 64'(d1), 64'h1234_5678);
        check("t2_ifu_rdata", 64'(d0), 64'h0000_0413);
        check("t2_lsu_latency", 64'(l1), 64'(RD_LAT + 2));
        check("t2_ifu_after_lsu", 64'(c0 - c1), 64'(RD_LAT + 3));

        // 3: write with W three cycles after AW, IFU pending throughout
        b_base = b_count; bdone = 0; bresp_seen = 2'b11;
        mon_ifu_block = 1'b1;
        lsu.awaddr = 32'h8000_0104; lsu.awvalid = 1'b1;
        ifu.araddr = 32'h8000_0008; ifu.arvalid = 1'b1;
        for (int n = 0; n < 64 && !bdone; n++) begin
            aw_f = lsu.awvalid && lsu.awready;
            w_f  = lsu.wvalid && lsu.wready;
            b_f  = lsu.bvalid && lsu.bready;
            if (b_f) bresp_seen = lsu.bresp;
            @(posedge clk); #1;
            if (aw_f) lsu.awvalid = 1'b0;
            if (w_f) lsu.wvalid = 1'b0;
            if (n == 2) begin lsu.wdata = 32'hDEAD_BEEF; lsu.wstrb = 4'hF; lsu.wvalid = 1'b1; end
            if (b_f) bdone = 1;
        end
        mon_ifu_block = 1'b0;
        check("t3_b_done", 64'(bdone), 64'd1);
        check("t3_bresp", 64'(bresp_seen), 64'd0);
        check("t3_b_count", 64'(b_count - b_base), 64'd1);
        check("t3_mem_awaddr", 64'(wa_q), 64'h8000_0104);
        check("t3_mem_wdata", 64'(wd_q), 64'hDEAD_BEEF);
        check("t3_mem_wstrb", 64'(ws_q), 64'hF);
        check("t3_ifu_held_off", 64'(ifu_leak), 64'd0);
        do_read(0, 32'h8000_0008, d0, r0, l0, c0);
        check("t3_ifu_rdata", 64'(d0), 64'h25A5_A5AD);
        check("t3_ifu_latency", 64'(l0), 64'(RD_LAT + 2));

        // 4: SLVERR forwarded, then a clean fetch
        do_read(1, 32'h0000_0000, d1, r1, l1, c1);
        check("t4_lsu_rresp", 64'(r1), 64'(2'b10));
        check("t4_state_idle", 64'(dut.state), 64'(IDLE));
        do_read(0, 32'h8000_0000, d0, r0, l0, c0);
        check("t4_ifu_rdata", 64'(d0), 64'h0000_0413);
        check("t4_ifu_rresp", 64'(r0), 64'd0);

        // 5: reset while LSU read is outstanding
        lsu.araddr = 32'h8000_1000; lsu.arvalid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_in_lsu_rd", 64'(dut.state), 64'(LSU_RD));
        rst = 1'b1; lsu.arvalid = 1'b0;
        #1;
        check("t5_state_idle", 64'(dut.state), 64'(IDLE));
        check("t5_outputs_zero", 64'(any_out()), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (lsu.rvalid) seen++;
        end
        check("t5_no_stale_rvalid", 64'(seen), 64'd0);

        // 6: 16 back-to-back fetches with arvalid held high
        ar_base = ar_count; ar_n = 0; r_n = 0; idle_cnt = 0; last_r = -1;
        gap_bad = 0; idle_bad = 0;
        exp_addr = 32'h8000_2000;
        ifu.araddr = 32'h8000_2000; ifu.arvalid = 1'b1;
        for (int n = 0; n < 400 && r_n < 16; n++) begin
            aw_f = ifu.arvalid && ifu.arready;
            b_f  = ifu.rvalid && ifu.rready;
            if (dut.state == IDLE) idle_cnt++;
            if (b_f) begin
                check("t6_rdata", 64'(ifu.rdata), 64'(exp_addr ^ 32'hA5A5_A5A5));
                if (last_r >= 0 && (cyc - last_r) != RD_LAT + 3) gap_bad++;
                if (idle_cnt != 1) idle_bad++;
                last_r = cyc; idle_cnt = 0; r_n++;
                exp_addr = exp_addr + 32'd4;
            end
            @(posedge clk); #1;
            if (aw_f) begin
                ar_n++;
                if (ar_n == 16) ifu.arvalid = 1'b0;
                else ifu.araddr = ifu.araddr + 32'd4;
            end
        end
        check("t6_beats", 64'(r_n), 64'd16);
        check("t6_mem_ar_count", 64'(ar_count - ar_base), 64'd16);
        check("t6_gap", 64'(gap_bad), 64'd0);
        check("t6_single_idle", 64'(idle_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
